// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: entry type codes and field widths.
// Used by the ROB itself, the issue unit and the load/store buffer.
package rob_pkg;

    localparam int ROB_TYPE_WIDTH = 2;
    localparam int RD_ID_WIDTH    = 5;

    typedef logic [ROB_TYPE_WIDTH-1:0] rob_type_t;

    localparam rob_type_t ROB_REG    = 2'd0;
    localparam rob_type_t ROB_BRANCH = 2'd1;
    localparam rob_type_t ROB_STORE  = 2'd2;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order commit queue. Hands out one tag per issued instruction,
// captures CDB results, retires the oldest entry each cycle and raises a
// one-cycle flush pulse when a mispredicted branch reaches the head.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB_WIDTH = 4,
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 issue_signal,
    input  logic [1:0]           issue_type,
    input  logic [4:0]           issue_rd_id,
    output logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 rob_full,
    input  logic                 wb_signal,
    input  logic [ROB_WIDTH-1:0] wb_tag,
    input  logic [REG_WIDTH-1:0] wb_value,
    input  logic                 wb_mispredict,
    input  logic [REG_WIDTH-1:0] wb_target_pc,
    input  logic [ROB_WIDTH-1:0] query_tag_1,
    input  logic [ROB_WIDTH-1:0] query_tag_2,
    output logic                 query_ready_1,
    output logic                 query_ready_2,
    output logic [REG_WIDTH-1:0] query_value_1,
    output logic [REG_WIDTH-1:0] query_value_2,
    output logic                 rob_commit_signal,
    output logic [REG_WIDTH-1:0] commit_rd_value,
    output logic [ROB_WIDTH-1:0] commit_rd_tag,
    output logic                 commit_store_signal,
    output logic                 clear_signal,
    output logic [REG_WIDTH-1:0] clear_pc
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH-1:0] PTR_ONE    = {{(ROB_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ROB_WIDTH:0]   CNT_ONE    = {{ROB_WIDTH{1'b0}}, 1'b1};
    localparam logic [ROB_WIDTH:0]   FULL_COUNT = {1'b1, {ROB_WIDTH{1'b0}}};

    logic [ROB_WIDTH-1:0]   head_reg;
    logic [ROB_WIDTH-1:0]   tail_reg;
    logic [ROB_WIDTH:0]     count_reg;

    logic                   busy_reg       [DEPTH];
    logic                   ready_reg      [DEPTH];
    rob_type_t              type_reg       [DEPTH];
    logic [RD_ID_WIDTH-1:0] rd_id_reg      [DEPTH];
    logic [REG_WIDTH-1:0]   value_reg      [DEPTH];
    logic                   mispredict_reg [DEPTH];
    logic [REG_WIDTH-1:0]   target_pc_reg  [DEPTH];

    logic                   clear_signal_reg;
    logic [REG_WIDTH-1:0]   clear_pc_reg;

    logic                   issue_en;
    logic                   wb_en;
    logic                   commit_ok;
    logic                   flush;
    rob_type_t              head_type;

    assign head_type = type_reg[head_reg];
    assign rob_full  = (count_reg == FULL_COUNT);
    assign issue_tag = tail_reg;

    // While a flush pulse is out, nothing new enters or retires.
    assign issue_en  = rdy_in & issue_signal & ~rob_full & ~clear_signal_reg;
    assign wb_en     = rdy_in & wb_signal & busy_reg[wb_tag] & ~clear_signal_reg;
    assign commit_ok = rdy_in & (count_reg != '0) & ready_reg[head_reg] & ~clear_signal_reg;
    assign flush     = commit_ok & (head_type == ROB_BRANCH) & mispredict_reg[head_reg];

    assign rob_commit_signal   = commit_ok & (head_type != ROB_STORE) & (rd_id_reg[head_reg] != '0);
    assign commit_store_signal = commit_ok & (head_type == ROB_STORE);
    assign commit_rd_value     = value_reg[head_reg];
    assign commit_rd_tag       = head_reg;

    assign clear_signal = clear_signal_reg;
    assign clear_pc     = clear_pc_reg;

    // Operand lookup ports; a result on the CDB this cycle beats the stored copy.
    logic [ROB_WIDTH-1:0] q_tag   [2];
    logic                 q_ready [2];
    logic [REG_WIDTH-1:0] q_value [2];

    assign q_tag[0]      = query_tag_1;
    assign q_tag[1]      = query_tag_2;
    assign query_ready_1 = q_ready[0];
    assign query_ready_2 = q_ready[1];
    assign query_value_1 = q_value[0];
    assign query_value_2 = q_value[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_query
        logic bypass;
        assign bypass      = wb_signal & (wb_tag == q_tag[gi]);
        assign q_ready[gi] = ready_reg[q_tag[gi]] | bypass;
        assign q_value[gi] = bypass ? wb_value : value_reg[q_tag[gi]];
    end

    // Head/tail/count bookkeeping; a flush empties the queue at the commit edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (commit_ok) head_reg <= head_reg + PTR_ONE;
            if (issue_en)  tail_reg <= tail_reg + PTR_ONE;
            unique case ({issue_en, commit_ok})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Flush pulse: set by the mispredict commit, cleared on the next live cycle, held when stalled.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            clear_signal_reg <= 1'b0;
            clear_pc_reg     <= '0;
        end else if (rdy_in) begin
            clear_signal_reg <= flush;
            if (flush) clear_pc_reg <= target_pc_reg[head_reg];
        end
    end

    // Entry storage: writeback capture, retirement, and allocation at the tail.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_reg[i]       <= 1'b0;
                ready_reg[i]      <= 1'b0;
                type_reg[i]       <= ROB_REG;
                rd_id_reg[i]      <= '0;
                value_reg[i]      <= '0;
                mispredict_reg[i] <= 1'b0;
                target_pc_reg[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_reg[i]  <= 1'b0;
                ready_reg[i] <= 1'b0;
            end
        end else begin
            if (wb_en) begin
                ready_reg[wb_tag]      <= 1'b1;
                value_reg[wb_tag]      <= wb_value;
                mispredict_reg[wb_tag] <= wb_mispredict;
                target_pc_reg[wb_tag]  <= wb_target_pc;
            end
            if (commit_ok) begin
                busy_reg[head_reg] <= 1'b0;
            end
            // Tail never aliases a live entry here: issue is blocked when full.
            if (issue_en) begin
                busy_reg[tail_reg]       <= 1'b1;
                ready_reg[tail_reg]      <= (issue_type == ROB_STORE);
                type_reg[tail_reg]       <= issue_type;
                rd_id_reg[tail_reg]      <= issue_rd_id;
                value_reg[tail_reg]      <= '0;
                mispredict_reg[tail_reg] <= 1'b0;
                target_pc_reg[tail_reg]  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, a fill/wrap
// sequence, randomized traffic against a queue-based model, and a reset
// applied in the middle of a flush pulse.
module tb_reorder_buffer;
    import rob_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy = 1'b0;
    logic        issue_signal = 1'b0;
    logic [1:0]  issue_type = 2'd0;
    logic [4:0]  issue_rd_id = 5'd0;
    logic [3:0]  issue_tag;
    logic        rob_full;
    logic        wb_signal = 1'b0;
    logic [3:0]  wb_tag = 4'd0;
    logic [31:0] wb_value = 32'd0;
    logic        wb_mispredict = 1'b0;
    logic [31:0] wb_target_pc = 32'd0;
    logic [3:0]  query_tag_1 = 4'd0;
    logic [3:0]  query_tag_2 = 4'd0;
    logic        query_ready_1, query_ready_2;
    logic [31:0] query_value_1, query_value_2;
    logic        rob_commit_signal;
    logic [31:0] commit_rd_value;
    logic [3:0]  commit_rd_tag;
    logic        commit_store_signal;
    logic        clear_signal;
    logic [31:0] clear_pc;

    reorder_buffer #(.ROB_WIDTH(4), .REG_WIDTH(32)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
        .issue_signal(issue_signal), .issue_type(issue_type), .issue_rd_id(issue_rd_id),
        .issue_tag(issue_tag), .rob_full(rob_full),
        .wb_signal(wb_signal), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_mispredict(wb_mispredict), .wb_target_pc(wb_target_pc),
        .query_tag_1(query_tag_1), .query_tag_2(query_tag_2),
        .query_ready_1(query_ready_1), .query_ready_2(query_ready_2),
        .query_value_1(query_value_1), .query_value_2(query_value_2),
        .rob_commit_signal(rob_commit_signal), .commit_rd_value(commit_rd_value),
        .commit_rd_tag(commit_rd_tag), .commit_store_signal(commit_store_signal),
        .clear_signal(clear_signal), .clear_pc(clear_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a queue of in-flight instructions ----------------
    typedef struct {
        logic [1:0]  typ;
        logic [4:0]  rd;
        bit          ready;
        logic [31:0] val;
        bit          mp;
        logic [31:0] tpc;
    } ent_t;

    ent_t        mq[$];
    int          m_head = 0;
    bit          m_clear = 1'b0;
    logic [31:0] m_clear_pc = 32'd0;

    function automatic int tag_index(input logic [3:0] tag);
        return (int'(tag) - m_head + DEPTH) % DEPTH;
    endfunction

    task automatic check_query(input string name, input logic [3:0] qt,
                               input logic qr, input logic [31:0] qv);
        int k;
        if (wb_signal && wb_tag == qt) begin
            chk({name, " ready(bypass)"}, qr, 1);
            chk({name, " value(bypass)"}, qv, wb_value);
        end else begin
            k = tag_index(qt);
            if (k < mq.size()) begin
                chk({name, " ready"}, qr, mq[k].ready);
                if (mq[k].ready) chk({name, " value"}, qv, mq[k].val);
            end
        end
    endtask

    task automatic model_check();
        int sz;
        bit cok;
        sz  = mq.size();
        cok = 1'b0;
        if (sz > 0) cok = rdy && mq[0].ready && !m_clear;
        chk("rob_full", rob_full, (sz == DEPTH));
        chk("issue_tag", issue_tag, (m_head + sz) % DEPTH);
        chk("commit_rd_tag", commit_rd_tag, m_head);
        chk("rob_commit_signal", rob_commit_signal,
            cok && mq[0].typ != ROB_STORE && mq[0].rd != 0);
        chk("commit_store_signal", commit_store_signal, cok && mq[0].typ == ROB_STORE);
        if (cok && mq[0].typ != ROB_STORE && mq[0].rd != 0)
            chk("commit_rd_value", commit_rd_value, mq[0].val);
        chk("clear_signal", clear_signal, m_clear);
        if (m_clear) chk("clear_pc", clear_pc, m_clear_pc);
        check_query("query_1", query_tag_1, query_ready_1, query_value_1);
        check_query("query_2", query_tag_2, query_ready_2, query_value_2);
    endtask

    task automatic model_step();
        int sz, k;
        bit full, cok, flush;
        logic [31:0] fpc;
        ent_t e;
        if (!rdy) return;
        if (m_clear) begin
            m_clear = 1'b0;
            return;
        end
        sz = mq.size();
        full = (sz == DEPTH);
        cok = 1'b0; flush = 1'b0; fpc = 32'd0;
        if (sz > 0) begin
            cok   = mq[0].ready;
            flush = cok && mq[0].typ == ROB_BRANCH && mq[0].mp;
            fpc   = mq[0].tpc;
        end
        if (wb_signal) begin
            k = tag_index(wb_tag);
            if (k < sz) begin
                e = mq[k];
                e.ready = 1'b1; e.val = wb_value; e.mp = wb_mispredict; e.tpc = wb_target_pc;
                mq[k] = e;
            end
        end
        if (flush) begin
            mq.delete();
            m_head = 0;
            m_clear = 1'b1;
            m_clear_pc = fpc;
            return;
        end
        if (cok) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (issue_signal && !full) begin
            e.typ = issue_type; e.rd = issue_rd_id; e.ready = (issue_type == ROB_STORE);
            e.val = 32'd0; e.mp = 1'b0; e.tpc = 32'd0;
            mq.push_back(e);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_head = 0;
        m_clear = 1'b0;
        m_clear_pc = 32'd0;
    endtask

    // ---------------- cycle helpers ----------------
    task automatic set_idle();
        rdy = 1'b1; issue_signal = 1'b0; issue_type = ROB_REG; issue_rd_id = 5'd0;
        wb_signal = 1'b0; wb_tag = 4'd0; wb_value = 32'd0; wb_mispredict = 1'b0;
        wb_target_pc = 32'd0; query_tag_1 = 4'd0; query_tag_2 = 4'd0;
    endtask

    task automatic pre_edge();
        #1;
        model_check();
    endtask

    task automatic post_edge();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        #1;
        chk("reset rob_full", rob_full, 0);
        chk("reset issue_tag", issue_tag, 0);
        chk("reset commit", rob_commit_signal, 0);
        chk("reset store", commit_store_signal, 0);
        chk("reset commit_rd_value", commit_rd_value, 0);
        chk("reset commit_rd_tag", commit_rd_tag, 0);
        chk("reset clear_signal", clear_signal, 0);
        chk("reset clear_pc", clear_pc, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rdy; bit iss; bit [1:0] ityp; bit [4:0] ird;
        bit wb; bit [3:0] wtag; bit [31:0] wval; bit wmp; bit [31:0] wpc;
        bit [3:0] qtag; bit qchk;
        bit [3:0] e_itag; bit e_commit; bit [31:0] e_cval; bit [3:0] e_ctag;
        bit e_store; bit e_clear; bit [31:0] e_cpc; bit e_qrdy; bit [31:0] e_qval;
    } vec_t;

    vec_t tbl[37];

    initial begin
        // rdy iss ityp ird | wb wtag wval wmp wpc | qtag qchk | itag commit cval ctag store clear cpc qrdy qval
        tbl[0]  = '{1,0,ROB_REG,0,    0,0,0,0,0,             0,0, 0,0,0,0,0,0,0,0,0};
        tbl[1]  = '{1,1,ROB_REG,1,    0,0,0,0,0,             0,0, 0,0,0,0,0,0,0,0,0};
        tbl[2]  = '{1,1,ROB_REG,2,    0,0,0,0,0,             0,0, 1,0,0,0,0,0,0,0,0};
        tbl[3]  = '{1,1,ROB_REG,3,    0,0,0,0,0,             0,0, 2,0,0,0,0,0,0,0,0};
        tbl[4]  = '{1,0,ROB_REG,0,    0,0,0,0,0,             0,0, 3,0,0,0,0,0,0,0,0};
        tbl[5]  = '{1,0,ROB_REG,0,    1,1,'hAA,0,0,          1,1, 3,0,0,0,0,0,0,1,'hAA};
        tbl[6]  = '{1,0,ROB_REG,0,    1,0,'h55,0,0,          1,1, 3,0,0,0,0,0,0,1,'hAA};
        tbl[7]  = '{1,0,ROB_REG,0,    0,0,0,0,0,             0,0, 3,1,'h55,0,0,0,0,0,0};
        tbl[8]  = '{1,0,ROB_REG,0,    0,0,0,0,0,             0,0, 3,1,'hAA,1,0,0,0,0,0};
        tbl[9]  = '{1,0,ROB_REG,0,    0,0,0,0,0,             0,0, 3,0,0,2,0,0,0,0,0};
        tbl[10] = '{1,1,ROB_REG,4,    0,0,0,0,0,             0,0, 3,0,0,2,0,0,0,0,0};
        tbl[11] = '{1,1,ROB_REG,5,    0,0,0,0,0,             0,0, 4,0,0,2,0,0,0,0,0};
        tbl[12] = '{1,1,ROB_REG,6,    0,0,0,0,0,             0,0, 5,0,0,2,0,0,0,0,0};
        tbl[13] = '{1,0,ROB_REG,0,    1,5,'h1234,0,0,        5,1, 6,0,0,2,0,0,0,1,'h1234};
        tbl[14] = '{1,0,ROB_REG,0,    0,0,0,0,0,             5,1, 6,0,0,2,0,0,0,1,'h1234};
        tbl[15] = '{1,0,ROB_REG,0,    1,2,'h22,0,0,          0,0, 6,0,0,2,0,0,0,0,0};
        tbl[16] = '{1,0,ROB_REG,0,    0,0,0,0,0,             0,0, 6,1,'h22,2,0,0,0,0,0};
        tbl[17] = '{1,0,ROB_REG,0,    1,3,'h33,0,0,          0,0, 6,0,0,3,0,0,0,0,0};
        tbl[18] = '{1,0,ROB_REG,0,    1,4,'h44,0,0,          0,0, 6,1,'h33,3,0,0,0,0,0};
        tbl[19] = '{1,0,ROB_REG,0,    0,0,0,0,0,             0,0, 6,1,'h44,4,0,0,0,0,0};
        tbl[20] = '{1,0,ROB_REG,0,    0,0,0,0,0,             0,0, 6,1,'h1234,5,0,0,0,0,0};
        tbl[21] = '{0,1,ROB_REG,7,    0,0,0,0,0,             0,0, 6,0,0,6,0,0,0,0,0};
        tbl[22] = '{1,0,ROB_REG,0,    0,0,0,0,0,             0,0, 6,0,0,6,0,0,0,0,0};
        tbl[23] = '{1,1,ROB_STORE,0,  0,0,0,0,0,             0,0, 6,0,0,6,0,0,0,0,0};
        tbl[24] = '{1,0,ROB_REG,0,    0,0,0,0,0,             0,0, 7,0,0,6,1,0,0,0,0};
        tbl[25] = '{1,1,ROB_REG,0,    0,0,0,0,0,             0,0, 7,0,0,7,0,0,0,0,0};
        tbl[26] = '{1,0,ROB_REG,0,    1,7,'h77,0,0,          0,0, 8,0,0,7,0,0,0,0,0};
        tbl[27] = '{1,0,ROB_REG,0,    0,0,0,0,0,             0,0, 8,0,0,7,0,0,0,0,0};
        tbl[28] = '{1,0,ROB_REG,0,    0,0,0,0,0,             0,0, 8,0,0,8,0,0,0,0,0};
        tbl[29] = '{1,1,ROB_BRANCH,10,0,0,0,0,0,             0,0, 8,0,0,8,0,0,0,0,0};
        tbl[30] = '{1,1,ROB_REG,9,    0,0,0,0,0,             0,0, 9,0,0,8,0,0,0,0,0};
        tbl[31] = '{1,0,ROB_REG,0,    1,8,'hB0,1,'h100,      0,0, 10,0,0,8,0,0,0,0,0};
        tbl[32] = '{1,1,ROB_REG,11,   0,0,0,0,0,             0,0, 10,1,'hB0,8,0,0,0,0,0};
        tbl[33] = '{0,0,ROB_REG,0,    1,9,'h99,0,0,          0,0, 0,0,0,0,0,1,'h100,0,0};
        tbl[34] = '{1,1,ROB_REG,12,   1,9,'h99,0,0,          0,0, 0,0,0,0,0,1,'h100,0,0};
        tbl[35] = '{1,0,ROB_REG,0,    0,0,0,0,0,             9,1, 0,0,0,0,0,0,0,0,0};
        tbl[36] = '{1,0,ROB_REG,0,    0,0,0,0,0,             0,0, 0,0,0,0,0,0,0,0,0};
    end

    // ---------------- main sequence ----------------
    initial begin
        #2;
        do_reset();

        // Directed table: in-order commit, bypass, stall, store, rd=0, mispredict flush.
        for (int i = 0; i < 37; i++) begin
            rdy = tbl[i].rdy; issue_signal = tbl[i].iss; issue_type = tbl[i].ityp;
            issue_rd_id = tbl[i].ird; wb_signal = tbl[i].wb; wb_tag = tbl[i].wtag;
            wb_value = tbl[i].wval; wb_mispredict = tbl[i].wmp; wb_target_pc = tbl[i].wpc;
            query_tag_1 = tbl[i].qtag; query_tag_2 = 4'(15 - int'(tbl[i].qtag));
            pre_edge();
            chk($sformatf("row%0d issue_tag", i), issue_tag, tbl[i].e_itag);
            chk($sformatf("row%0d rob_full", i), rob_full, 0);
            chk($sformatf("row%0d commit", i), rob_commit_signal, tbl[i].e_commit);
            if (tbl[i].e_commit) chk($sformatf("row%0d commit_value", i), commit_rd_value, tbl[i].e_cval);
            chk($sformatf("row%0d commit_tag", i), commit_rd_tag, tbl[i].e_ctag);
            chk($sformatf("row%0d store", i), commit_store_signal, tbl[i].e_store);
            chk($sformatf("row%0d clear", i), clear_signal, tbl[i].e_clear);
            if (tbl[i].e_clear) chk($sformatf("row%0d clear_pc", i), clear_pc, tbl[i].e_cpc);
            if (tbl[i].qchk) begin
                chk($sformatf("row%0d query_ready", i), query_ready_1, tbl[i].e_qrdy);
                if (tbl[i].e_qrdy) chk($sformatf("row%0d query_value", i), query_value_1, tbl[i].e_qval);
            end
            $display("row %0d: issue_tag=%0d commit=%0b value=%h tag=%0d store=%0b clear=%0b",
                     i, issue_tag, rob_commit_signal, commit_rd_value, commit_rd_tag,
                     commit_store_signal, clear_signal);
            post_edge();
        end

        // Fill all 16 entries; the 17th issue must be ignored.
        set_idle();
        for (int i = 0; i < DEPTH; i++) begin
            issue_signal = 1'b1; issue_rd_id = 5'(i + 1);
            pre_edge();
            chk($sformatf("fill issue_tag %0d", i), issue_tag, i);
            $display("fill %0d: issue_tag=%0d full=%0b", i, issue_tag, rob_full);
            post_edge();
        end
        issue_rd_id = 5'd20;
        pre_edge();
        chk("full after 16", rob_full, 1);
        $display("issue while full: issue_tag=%0d full=%0b", issue_tag, rob_full);
        post_edge();
        set_idle();
        wb_signal = 1'b1; wb_tag = 4'd0; wb_value = 32'hF0;
        pre_edge();
        chk("17th issue ignored", issue_tag, 0);
        post_edge();
        // Head ready and issue in the same cycle while full: only the commit happens.
        set_idle();
        issue_signal = 1'b1; issue_rd_id = 5'd21;
        pre_edge();
        chk("full commit", rob_commit_signal, 1);
        chk("full commit value", commit_rd_value, 32'hF0);
        chk("still full", rob_full, 1);
        $display("commit while full: tag=%0d value=%h", commit_rd_tag, commit_rd_value);
        post_edge();
        pre_edge();
        chk("full deasserts", rob_full, 0);
        chk("tail wrapped", issue_tag, 0);
        post_edge();
        set_idle();
        pre_edge();
        chk("full reasserts", rob_full, 1);
        chk("tail after wrap", issue_tag, 1);
        post_edge();

        // Randomized traffic checked against the queue model.
        for (int c = 0; c < 3000; c++) begin
            int sz;
            sz = mq.size();
            rdy = ($urandom_range(0, 9) != 0);
            issue_signal = 1'($urandom_range(0, 1));
            issue_type = 2'($urandom_range(0, 2));
            issue_rd_id = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_signal = 1'($urandom_range(0, 1));
            if (sz > 0 && $urandom_range(0, 7) != 0)
                wb_tag = 4'((m_head + int'($urandom_range(0, sz - 1))) % DEPTH);
            else
                wb_tag = 4'($urandom_range(0, 15));
            wb_value = $urandom;
            wb_mispredict = ($urandom_range(0, 5) == 0);
            wb_target_pc = $urandom;
            query_tag_1 = ($urandom_range(0, 3) == 0) ? wb_tag : 4'($urandom_range(0, 15));
            query_tag_2 = 4'($urandom_range(0, 15));
            pre_edge();
            if (rob_commit_signal || commit_store_signal || clear_signal)
                $display("rand %0d: commit=%0b store=%0b tag=%0d value=%h clear=%0b",
                         c, rob_commit_signal, commit_store_signal, commit_rd_tag,
                         commit_rd_value, clear_signal);
            post_edge();
        end

        // Asynchronous reset while a flush pulse is out cancels it at once.
        do_reset();
        issue_signal = 1'b1; issue_type = ROB_BRANCH; issue_rd_id = 5'd0;
        pre_edge(); post_edge();
        set_idle();
        wb_signal = 1'b1; wb_tag = 4'd0; wb_mispredict = 1'b1; wb_target_pc = 32'h200;
        pre_edge(); post_edge();
        set_idle();
        pre_edge(); post_edge();
        set_idle();
        pre_edge();
        chk("pre-reset clear", clear_signal, 1);
        chk("pre-reset clear_pc", clear_pc, 32'h200);
        rst_n = 1'b0;
        #1;
        chk("mid-flush reset clear", clear_signal, 0);
        chk("mid-flush reset clear_pc", clear_pc, 0);
        chk("mid-flush reset issue_tag", issue_tag, 0);
        $display("mid-flush reset: clear=%0b clear_pc=%h", clear_signal, clear_pc);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
